mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_lane_align.sv | 38 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester RAM port arbiter: access sizes,
// FSM states, requester indices and the alignment rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Reserved size is treated as misaligned so it takes the error path.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size_e'(size))
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane steering: store write enables and replicated data,
// plus load extraction with zero/sign extension.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_we,
  output logic [31:0] o_din,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift = i_rword >> {i_addr_lo, 3'b000};
    o_we    = 4'b1111;
    o_din   = i_wdata;
    o_rdata = w_shift;
    case (size_e'(i_size))
      SZ_BYTE: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_din   = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_din   = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the LSU and loader onto one RAM port; one transaction in flight,
// misaligned requests complete with an error without touching the RAM.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 17,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [3:0]        req_size,
  input  logic [1:0]        req_signed,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic [1:0]        req_gnt,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready,
  input  logic              mem_rvalid
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e            r_state;
  logic              r_last;
  logic              r_idx;
  logic              r_we;
  logic              r_signed;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [TW-1:0]     r_tmo;
  logic              r_mem_en;
  logic [1:0]        r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_any;
  logic              w_win;
  logic [1:0]        w_gnt;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic              w_mis;
  logic              w_done;
  logic [3:0]        w_we;
  logic [31:0]       w_din;
  logic [31:0]       w_rdata;

  // On a tie the pointer names the previous winner, so the other side goes.
  assign w_any  = |req_valid;
  assign w_win  = (req_valid == 2'b11) ? ((PRIO_MODE != 0) ? REQ_LDR : ~r_last) : req_valid[1];
  assign w_gnt  = (r_state == ST_IDLE && w_any && !reset) ? {w_win, ~w_win} : 2'b00;
  assign w_size = w_win ? req_size[3:2] : req_size[1:0];
  assign w_addr = w_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign w_mis  = misaligned(w_size, w_addr[1:0]);
  assign w_done = r_we ? mem_ready : mem_rvalid;

  mem_lane_align u_align (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_signed  (r_signed),
    .i_wdata   (r_wdata),
    .i_rword   (mem_dout),
    .o_we      (w_we),
    .o_din     (w_din),
    .o_rdata   (w_rdata)
  );

  assign req_gnt   = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = (r_mem_en && r_we) ? w_we : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_din   = w_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= REQ_LDR;
      r_idx       <= REQ_LSU;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_tmo       <= '0;
      r_mem_en    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_last   <= w_win;
          r_idx    <= w_win;
          r_we     <= req_we[w_win];
          r_signed <= req_signed[w_win];
          r_size   <= w_size;
          r_addr   <= w_addr;
          r_wdata  <= w_win ? req_wdata[63:32] : req_wdata[31:0];
          if (w_mis) begin
            r_state     <= ST_DONE;
            r_rsp_valid <= w_gnt;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_state  <= ST_ISSUE;
            r_mem_en <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_tmo   <= '0;
        end
        ST_WAIT: begin
          if (w_done || r_tmo == TMO_LAST) begin
            r_state     <= ST_DONE;
            r_mem_en    <= 1'b0;
            r_rsp_valid <= {r_idx, ~r_idx};
            r_rsp_err   <= ~w_done;
            r_rsp_rdata <= (w_done && !r_we) ? w_rdata : 32'h0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 2'b00;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
